// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: op codes, FSM states
// and the number of binary-weighted shift stages.
package shift_seq_pkg;

  localparam int NUM_STAGES = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Start/result handshake bundle shared by the execute-stage long-latency units.
interface shift_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             ctrl_start;
  logic [1:0]       ctrl_op;
  logic [WIDTH-1:0] data_operand;
  logic [4:0]       data_shamt;
  logic [WIDTH-1:0] data_result;
  logic             data_resultRDY;
  logic             data_exception;
  logic             busy;

  modport master (
    output ctrl_start, ctrl_op, data_operand, data_shamt,
    input  data_result, data_resultRDY, data_exception, busy
  );

  modport slave (
    input  ctrl_start, ctrl_op, data_operand, data_shamt,
    output data_result, data_resultRDY, data_exception, busy
  );

endinterface

// File: rtl/shift_stage_unit.sv
// One combinational shift stage: shifts by 2^index, left with zero fill or
// right with zero/sign fill.
module shift_stage_unit
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [2:0]       i_index,
  input  logic             i_left,
  input  logic             i_arith,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] w_cand [NUM_STAGES];
  logic             w_fill;

  // Right shifts take the sign from the value itself; it never changes across stages.
  assign w_fill = i_arith & i_value[WIDTH-1];

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    localparam int SH = 1 << gi;
    assign w_cand[gi] = i_left ? {i_value[WIDTH-1-SH:0], {SH{1'b0}}}
                               : {{SH{w_fill}}, i_value[WIDTH-1:SH]};
  end

  assign o_value = (i_index < 3'(NUM_STAGES)) ? w_cand[i_index] : i_value;

endmodule

// File: rtl/shift_sequencer.sv
// Shift unit that walks one shared stage through 16/8/4/2/1 over five cycles,
// giving a fixed six-cycle start-to-result latency.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  shift_sequencer_if.slave bus
);

  state_e           r_state;
  logic [2:0]       r_index;
  logic [4:0]       r_shamt;
  op_e              r_op;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_result;
  logic             r_rdy;
  logic             r_exc;
  logic             r_busy;

  state_e           w_state_next;
  logic [2:0]       w_index_next;
  logic [4:0]       w_shamt_next;
  op_e              w_op_next;
  logic [WIDTH-1:0] w_work_next;
  logic [WIDTH-1:0] w_result_next;
  logic             w_rdy_next;
  logic             w_exc_next;
  logic             w_busy_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_stage_out;

  shift_stage_unit #(.WIDTH(WIDTH)) u_stage (
    .i_value (r_work),
    .i_index (r_index),
    .i_left  (r_op == OP_SLL),
    .i_arith (r_op == OP_SRA),
    .o_value (w_stage_out)
  );

  assign w_accept = bus.ctrl_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_state == S_SHIFT) && (r_index == 3'd0);

  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    w_shamt_next = r_shamt;
    w_op_next    = r_op;
    w_work_next  = r_work;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_next = S_SHIFT;
          w_index_next = 3'(NUM_STAGES - 1);
          w_shamt_next = bus.data_shamt;
          w_op_next    = op_e'(bus.ctrl_op);
          w_work_next  = bus.data_operand;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        // An illegal op leaves the operand untouched so it comes back as the result.
        if (r_shamt[r_index] && r_op != OP_ILL) begin
          w_work_next = w_stage_out;
        end
        if (r_index == 3'd0) begin
          w_state_next = S_DONE;
          w_index_next = 3'(NUM_STAGES - 1);
        end else begin
          w_index_next = r_index - 3'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_index_next = 3'(NUM_STAGES - 1);
      end
    endcase

    w_rdy_next    = w_last;
    w_exc_next    = w_last && (r_op == OP_ILL);
    w_busy_next   = (w_state_next == S_SHIFT);
    w_result_next = w_last ? w_work_next : r_result;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_index  <= 3'(NUM_STAGES - 1);
      r_shamt  <= '0;
      r_op     <= OP_SLL;
      r_work   <= '0;
      r_result <= '0;
      r_rdy    <= 1'b0;
      r_exc    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_index  <= w_index_next;
      r_shamt  <= w_shamt_next;
      r_op     <= w_op_next;
      r_work   <= w_work_next;
      r_result <= w_result_next;
      r_rdy    <= w_rdy_next;
      r_exc    <= w_exc_next;
      r_busy   <= w_busy_next;
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_resultRDY = r_rdy;
  assign bus.data_exception = r_exc;
  assign bus.busy           = r_busy;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle logical/arithmetic shift unit that reuses one shared single-stage shift datapath over five cycles instead of instantiating a full five-level barrel shifter. It sits beside the ALU in the execute stage, alongside the multiplier/divider. It follows the same start/result-ready handshake so the pipeline stall logic treats all long-latency units identically.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width (fixed at 32; shamt is 5 bits)

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high; clears all state on the clock edge
- `ctrl_start`  in  1  start request; sampled only when not `busy`, or in the DONE cycle
- `ctrl_op`  in  2  00 = sll, 01 = srl, 10 = sra, 11 = illegal
- `data_operand`  in  32  value to shift; captured with `ctrl_start`
- `data_shamt`  in  5  shift amount 0–31; captured with `ctrl_start`
- `data_result`  out  32  shifted value; valid while `data_resultRDY` is high, then held until the next accepted start
- `data_resultRDY`  out  1  one-cycle pulse: result valid
- `data_exception`  out  1  high with `data_resultRDY` when `ctrl_op` = 11
- `busy`  out  1  high in SHIFT state

## Operation
- States are IDLE, SHIFT and DONE.
- IDLE:
  - If `ctrl_start` is high, latch operand into the working register, and latch shamt and op.
  - Clear the stage index to 4, then go to SHIFT.
- SHIFT: each cycle, apply stage k = index, where stage k shifts by 2^k (16, 8, 4, 2, 1).
  - If `shamt[k]` = 1, the working register takes the stage output; otherwise it holds.
  - Decrement the index. After stage 0, go to DONE.
- Stage rules:
  - sll fills zeros on the low end.
  - srl fills zeros on the high end.
  - sra fills with bit 31 of the *original latched operand*, which equals the working register's bit 31 at every stage.
- Illegal op (11): the working register is never modified, so the result equals the operand. `data_exception` pulses with `data_resultRDY`.
- DONE: assert `data_resultRDY` for exactly one cycle.
  - If `ctrl_start` is high in DONE, accept the new operation (back-to-back) and go to SHIFT.
  - Otherwise, go to IDLE.
- Latency is constant, independent of shamt. There is no zero-shift shortcut.
- `ctrl_start` while in SHIFT is ignored, not queued.
- Inputs other than at acceptance are don't-care.

## Timing
- Reset values:
  - state = IDLE, index = 4
  - `data_result` = 0, `data_resultRDY` = 0, `data_exception` = 0, `busy` = 0
- Cycle 0: `ctrl_start` high, accepted at the end of cycle 0.
- Cycles 1–5: `busy` = 1. Stages 16/8/4/2/1 are applied at the ends of cycles 1–5 respectively.
- Cycle 6: `data_resultRDY` = 1 and `data_result` is final. `busy` = 0.
- Throughput: one operation per 6 cycles with back-to-back starts in DONE. Otherwise the next start is at cycle 7 or later.
- Reset in any cycle (including SHIFT or DONE) wins over `ctrl_start`: the next cycle is IDLE with reset values. An in-flight operation produces no `data_resultRDY`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `shift_seq_pkg`:
  - op encodings (`OP_SLL`, `OP_SRL`, `OP_SRA`, `OP_ILL`)
  - state encoding (`S_IDLE`, `S_SHIFT`, `S_DONE`)
  - `NUM_STAGES` = 5
- Sub-module `shift_stage_unit`: purely combinational.
  - Inputs: 32-bit value, 3-bit stage index, direction, arithmetic flag.
  - Output: the value shifted by 2^index with the correct fill.
  - Instantiated once.
- Top level holds:
  - FSM, stage index counter
  - latched shamt/op, working register
  - ready/exception flags

## Test plan
- sll, operand 0x0000_00FF, shamt 8, start in cycle 0 -> `busy` high in cycles 1–5; `data_resultRDY` high in cycle 6 only; `data_result` = 0x0000_FF00; `data_exception` = 0.
- sra 0x8000_0000 shamt 31 -> 0xFFFF_FFFF; srl 0x8000_0000 shamt 31 -> 0x0000_0001; sra 0x7FFF_FFF0 shamt 4 -> 0x07FF_FFFF.
- shamt 0, sll, operand 0xDEAD_BEEF -> result 0xDEAD_BEEF, still in cycle 6 (constant latency).
- Start in cycle 0 (sll 0x1 by 1), second start with different data in cycle 3 -> second ignored; result 0x0000_0002 in cycle 6. Third start in cycle 6 (srl 0x100 by 4) -> accepted; result 0x0000_0010 in cycle 12.
- Reset asserted in cycle 3 of an operation -> cycle 4 onward: IDLE, all outputs 0; no `data_resultRDY` pulse ever appears for that operation.
- `ctrl_op` = 11, operand 0x1234_5678, shamt 7 -> cycle 6: `data_resultRDY` = 1, `data_exception` = 1, `data_result` = 0x1234_5678; exception low in cycle 7.
